// File: rtl/pmic_i2c_sequencer.sv
// PMIC bring-up sequencer: walks a command ROM and drives the I2C handler.
// Optional macro PMIC_SEQ_TIMEOUT_EN adds a WAIT_DONE timeout.
module pmic_i2c_sequencer #(
    parameter int ROM_ADDR_W     = 5,
    parameter int DELAY_UNIT     = 1000,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_seqDone,
    output logic                  o_error,
    output logic [ROM_ADDR_W-1:0] o_step,
    output logic [ROM_ADDR_W-1:0] o_romAddr,
    input  logic [24:0]           i_romData,
    output logic                  o_begin,
    output logic                  o_writeEnable,
    output logic [6:0]            o_i2cAddress,
    output logic [7:0]            o_regAddress,
    output logic [7:0]            o_txData,
    input  logic                  i_done
);
    localparam int CW = 8 + $clog2(DELAY_UNIT);
    localparam logic [ROM_ADDR_W-1:0] LAST_STEP = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_DELAY,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t                state, state_n;
    logic [ROM_ADDR_W-1:0] step, step_n;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  error_q, error_n;
    logic                  advance;
    logic [6:0]            i2c_addr;
    logic [7:0]            reg_addr;
    logic [7:0]            tx_data;

`ifdef PMIC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt, tcnt_n;
`endif

    always_comb begin
        state_n = state;
        step_n  = step;
        cnt_n   = cnt;
        error_n = error_q;
        advance = 1'b0;
`ifdef PMIC_SEQ_TIMEOUT_EN
        tcnt_n  = tcnt;
`endif
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    step_n  = '0;
                    error_n = 1'b0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                unique case (i_romData[24:23])
                    2'b00: state_n = S_ISSUE;
                    2'b01: begin
                        state_n = S_DELAY;
                        cnt_n   = CW'(i_romData[7:0]) * CW'(DELAY_UNIT);
                    end
                    2'b10: state_n = S_FINISH;
                    2'b11: state_n = S_ERROR;
                endcase
            end
            S_ISSUE: begin
                state_n = S_WAIT_DONE;
`ifdef PMIC_SEQ_TIMEOUT_EN
                tcnt_n  = '0;
`endif
            end
            S_WAIT_DONE: begin
                if (i_done) begin
                    advance = 1'b1;
`ifdef PMIC_SEQ_TIMEOUT_EN
                end else if (tcnt >= TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = S_ERROR;
                end else begin
                    tcnt_n = tcnt + 1'b1;
`endif
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_FINISH: state_n = S_IDLE;
            S_ERROR:  state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        // Running off the end of the table without an END entry is a fault
        if (advance) begin
            if (step == LAST_STEP) begin
                state_n = S_ERROR;
            end else begin
                step_n  = step + 1'b1;
                state_n = S_FETCH;
            end
        end
        if (state_n == S_ERROR) begin
            error_n = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            step     <= '0;
            rom_addr <= '0;
            cnt      <= '0;
            error_q  <= 1'b0;
            i2c_addr <= '0;
            reg_addr <= '0;
            tx_data  <= '0;
`ifdef PMIC_SEQ_TIMEOUT_EN
            tcnt     <= '0;
`endif
        end else begin
            state   <= state_n;
            step    <= step_n;
            cnt     <= cnt_n;
            error_q <= error_n;
`ifdef PMIC_SEQ_TIMEOUT_EN
            tcnt    <= tcnt_n;
`endif
            // Address is presented during FETCH so data lands in DECODE
            if (state_n == S_FETCH) begin
                rom_addr <= step_n;
            end
            if (state == S_DECODE) begin
                i2c_addr <= i_romData[22:16];
                reg_addr <= i_romData[15:8];
                tx_data  <= i_romData[7:0];
            end
        end
    end

    assign o_busy        = !(state inside {S_IDLE, S_FINISH, S_ERROR});
    assign o_begin       = (state == S_ISSUE);
    assign o_seqDone     = (state == S_FINISH);
    assign o_error       = error_q;
    assign o_step        = step;
    assign o_romAddr     = rom_addr;
    assign o_writeEnable = 1'b1;
    assign o_i2cAddress  = i2c_addr;
    assign o_regAddress  = reg_addr;
    assign o_txData      = tx_data;

endmodule
